// File: rtl/bp_pkg.sv
// Shared defaults, FSM state type and counter helper for the local branch predictor.
package bp_pkg;

   localparam int DEF_PC_W      = 10;
   localparam int DEF_LHT_IDX_W = 10;
   localparam int DEF_HIST_W    = 10;
   localparam int DEF_CTR_W     = 3;
   localparam int DEF_CTR_INIT  = 3;

   typedef enum logic {INIT, RUN} state_e;

   typedef logic [DEF_HIST_W-1:0] hist_t;
   typedef logic [DEF_CTR_W-1:0]  ctr_t;

   // Saturating step of a ctr_w-bit counter; never wraps at either end.
   function automatic int unsigned sat_update(input int unsigned ctr, input logic taken,
                                              input int unsigned ctr_w);
      int unsigned top_v;
      top_v = (32'd1 << ctr_w) - 32'd1;
      if (taken)
         return (ctr >= top_v) ? top_v : ctr + 32'd1;
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
   endfunction

endpackage

// File: rtl/bp_table_1r1w.sv
// 2**IDX_W x DAT_W table: registered read (write-first on index match), one write port,
// plus a combinational view of the write-index entry for read-modify-write updates.
module bp_table_1r1w #(
   parameter int IDX_W = 10,
   parameter int DAT_W = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [DAT_W-1:0] rd_dat,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [DAT_W-1:0] wr_dat,
   output logic [DAT_W-1:0] wr_old
);

   logic [DAT_W-1:0] mem [2**IDX_W];

   assign wr_old = mem[wr_idx];

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_idx] <= wr_dat;
   end

   always_ff @(posedge clock) begin
      if (reset)
         rd_dat <= '0;
      else if (rd_en)
         rd_dat <= (wr_en && (wr_idx == rd_idx)) ? wr_dat : mem[rd_idx];
   end

endmodule

// File: rtl/bp_local_predictor_param.sv
// Local-history predictor: LHT then LPT lookup, result 2 cycles after accept, no stalls;
// pred_ready is low only while the post-reset init sweep clears both tables.
module bp_local_predictor_param
   import bp_pkg::*;
#(
   parameter int PC_W      = DEF_PC_W,
   parameter int LHT_IDX_W = DEF_LHT_IDX_W,
   parameter int HIST_W    = DEF_HIST_W,
   parameter int CTR_W     = DEF_CTR_W,
   parameter int CTR_INIT  = DEF_CTR_INIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_ready,
   output logic              pred_out_valid,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_hist,
   output logic [CTR_W-1:0]  pred_ctr,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [HIST_W-1:0] upd_hist,
   input  logic              upd_taken,
   output logic              init_busy
);

   localparam int SW_W = (LHT_IDX_W > HIST_W) ? LHT_IDX_W : HIST_W;

   state_e            state_q, state_d;
   logic [SW_W-1:0]   idx_q, idx_d;
   logic              in_init;
   logic              accept;
   logic              s1_vld, s2_vld;
   logic [HIST_W-1:0] hist_q;

   logic                 lht_we;
   logic [LHT_IDX_W-1:0] lht_widx;
   logic [HIST_W-1:0]    lht_wdat, lht_old, lht_rd_dat;
   logic                 lpt_we;
   logic [HIST_W-1:0]    lpt_widx;
   logic [CTR_W-1:0]     lpt_wdat, lpt_old, lpt_rd_dat, lpt_sat;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         INIT: begin
            idx_d = idx_q + SW_W'(1);
            if (&idx_q)
               state_d = RUN;
         end
         default: ;
      endcase
   end

   assign in_init    = (state_q == INIT);
   assign init_busy  = in_init;
   assign pred_ready = !in_init;
   assign accept     = pred_valid && pred_ready;

   // Sweep writes own both write ports during INIT; updates are dropped there.
   assign lpt_sat  = CTR_W'(sat_update(32'(lpt_old), upd_taken, 32'(CTR_W)));
   assign lht_we   = !reset && (in_init ? (int'(idx_q) < 2**LHT_IDX_W) : upd_valid);
   assign lht_widx = in_init ? idx_q[LHT_IDX_W-1:0] : upd_pc[LHT_IDX_W-1:0];
   assign lht_wdat = in_init ? '0 : {lht_old[HIST_W-2:0], upd_taken};
   assign lpt_we   = !reset && (in_init ? (int'(idx_q) < 2**HIST_W) : upd_valid);
   assign lpt_widx = in_init ? idx_q[HIST_W-1:0] : upd_hist;
   assign lpt_wdat = in_init ? CTR_W'(CTR_INIT) : lpt_sat;

   bp_table_1r1w #(.IDX_W(LHT_IDX_W), .DAT_W(HIST_W)) u_lht (
      .clock  (clock),
      .reset  (reset),
      .rd_en  (accept),
      .rd_idx (pred_pc[LHT_IDX_W-1:0]),
      .rd_dat (lht_rd_dat),
      .wr_en  (lht_we),
      .wr_idx (lht_widx),
      .wr_dat (lht_wdat),
      .wr_old (lht_old)
   );

   // The LPT read register doubles as the pred_ctr output register.
   bp_table_1r1w #(.IDX_W(HIST_W), .DAT_W(CTR_W)) u_lpt (
      .clock  (clock),
      .reset  (reset),
      .rd_en  (s1_vld),
      .rd_idx (lht_rd_dat),
      .rd_dat (lpt_rd_dat),
      .wr_en  (lpt_we),
      .wr_idx (lpt_widx),
      .wr_dat (lpt_wdat),
      .wr_old (lpt_old)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         hist_q <= '0;
      end else begin
         s1_vld <= accept;
         s2_vld <= s1_vld;
         if (s1_vld)
            hist_q <= lht_rd_dat;
      end
   end

   assign pred_out_valid = s2_vld;
   assign pred_hist      = hist_q;
   assign pred_ctr       = lpt_rd_dat;
   assign pred_taken     = lpt_rd_dat[CTR_W-1];

endmodule

// File: tb/tb_bp_local_predictor_param.sv
// Directed plus random bench for bp_local_predictor_param against an array-based reference model.
module tb_bp_local_predictor_param;
   import bp_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pred_valid = 1'b0;
   logic [9:0] pred_pc = '0;
   logic       pred_ready;
   logic       pred_out_valid;
   logic       pred_taken;
   logic [9:0] pred_hist;
   logic [2:0] pred_ctr;
   logic       upd_valid = 1'b0;
   logic [9:0] upd_pc = '0;
   logic [9:0] upd_hist = '0;
   logic       upd_taken = 1'b0;
   logic       init_busy;

   int errors = 0;
   int checks = 0;

   // Reference model state: whole tables as arrays, one in-flight lookup, output copy.
   int lht_m [1024];
   int lpt_m [1024];
   int init_cnt = 0;
   bit busy = 1'b1;
   bit s1v = 1'b0;
   int s1h = 0;
   bit ov = 1'b0;
   int ohist = 0;
   int octr = 0;

   bp_local_predictor_param dut (
      .clock          (clock),
      .reset          (reset),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_ready     (pred_ready),
      .pred_out_valid (pred_out_valid),
      .pred_taken     (pred_taken),
      .pred_hist      (pred_hist),
      .pred_ctr       (pred_ctr),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_hist       (upd_hist),
      .upd_taken      (upd_taken),
      .init_busy      (init_busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge as the specification describes it: updates land first (write-first),
   // the older lookup reads the counter, the newly accepted lookup reads the history.
   task automatic model_edge();
      int i;
      if (reset) begin
         init_cnt = 0; busy = 1'b1; s1v = 1'b0; ov = 1'b0; ohist = 0; octr = 0;
      end else if (busy) begin
         lht_m[init_cnt] = 0;
         lpt_m[init_cnt] = 3;
         init_cnt++;
         if (init_cnt == 1024) busy = 1'b0;
         ov = 1'b0;
      end else begin
         if (upd_valid) begin
            i = int'(upd_pc) % 1024;
            lht_m[i] = (lht_m[i] * 2 + int'(upd_taken)) % 1024;
            if (upd_taken) lpt_m[upd_hist] = (lpt_m[upd_hist] == 7) ? 7 : lpt_m[upd_hist] + 1;
            else           lpt_m[upd_hist] = (lpt_m[upd_hist] == 0) ? 0 : lpt_m[upd_hist] - 1;
         end
         ov = s1v;
         if (s1v) begin
            ohist = s1h;
            octr  = lpt_m[s1h];
         end
         s1v = pred_valid;
         if (pred_valid) s1h = lht_m[int'(pred_pc) % 1024];
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_edge();
      #1;
      chk("init_busy", 32'(init_busy), 32'(busy));
      chk("pred_ready", 32'(pred_ready), 32'(!busy));
      chk("pred_out_valid", 32'(pred_out_valid), 32'(ov));
      chk("pred_hist", 32'(pred_hist), ohist);
      chk("pred_ctr", 32'(pred_ctr), octr);
      chk("pred_taken", 32'(pred_taken), (octr >> 2) & 1);
   endtask

   task automatic upd(input int pc, input int h, input bit t);
      upd_valid = 1'b1; upd_pc = 10'(pc); upd_hist = 10'(h); upd_taken = t;
   endtask

   task automatic predict_and_wait(input int pc);
      pred_valid = 1'b1; pred_pc = 10'(pc);
      cyc();
      pred_valid = 1'b0;
      cyc();
   endtask

   initial begin
      int n;
      int pulses;
      int first;

      // 1: reset, sweep length, first prediction sees cleared tables
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n = 0;
      while (init_busy === 1'b1 && n < 1100) begin n++; cyc(); end
      chk("init_len", n, 1024);
      predict_and_wait(10'h3FF);
      chk("t1_valid", 32'(pred_out_valid), 1);
      chk("t1_hist", 32'(pred_hist), 0);
      chk("t1_ctr", 32'(pred_ctr), 3);
      chk("t1_taken", 32'(pred_taken), 0);

      // 2: history shift
      for (int k = 0; k < 4; k++) begin upd(5, 0, 1'b1); cyc(); end
      upd_valid = 1'b0;
      predict_and_wait(5);
      chk("t2_hist", 32'(pred_hist), 10'h00F);

      // 3: counter saturation both ways
      for (int k = 0; k < 5; k++) begin upd(100, 10'h00F, 1'b1); cyc(); end
      upd_valid = 1'b0;
      predict_and_wait(5);
      chk("t3_ctr_hi", 32'(pred_ctr), 7);
      chk("t3_taken_hi", 32'(pred_taken), 1);
      for (int k = 0; k < 8; k++) begin upd(100, 10'h00F, 1'b0); cyc(); end
      upd_valid = 1'b0;
      predict_and_wait(5);
      chk("t3_ctr_lo", 32'(pred_ctr), 0);

      // 4: LHT bypass in S1, then LPT bypass in S2
      pred_valid = 1'b1; pred_pc = 10'd5; upd(5, 1, 1'b1);
      cyc();
      pred_valid = 1'b0; upd_valid = 1'b0;
      cyc();
      chk("t4_lht_bypass", 32'(pred_hist), 10'h01F);
      chk("t4_ctr", 32'(pred_ctr), 3);
      pred_valid = 1'b1; pred_pc = 10'd5;
      cyc();
      pred_valid = 1'b0; upd(200, 10'h01F, 1'b1);
      cyc();
      upd_valid = 1'b0;
      chk("t4_lpt_bypass", 32'(pred_ctr), 4);

      // 5: reset mid-RUN and mid-sweep with requests held high
      pred_valid = 1'b1; pred_pc = 10'd5;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 500; k++) begin cyc(); if (pred_out_valid === 1'b1) pulses++; end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n = 0;
      while (init_busy === 1'b1 && n < 1100) begin
         n++;
         if (pred_out_valid === 1'b1) pulses++;
         cyc();
      end
      chk("t5_init_len", n, 1024);
      chk("t5_no_output", pulses, 0);
      pred_valid = 1'b0;
      cyc();

      // random mix, small index ranges to force collisions and bypasses
      for (int k = 0; k < 3000; k++) begin
         pred_valid = 1'($urandom_range(0, 1));
         pred_pc    = 10'($urandom_range(0, 15));
         upd_valid  = 1'($urandom_range(0, 1));
         upd_pc     = 10'($urandom_range(0, 15));
         upd_hist   = 10'($urandom_range(0, 31));
         upd_taken  = 1'($urandom_range(0, 1));
         cyc();
      end
      upd_valid = 1'b0; pred_valid = 1'b0;
      cyc(); cyc();

      // 6: back-to-back requests for pc 0..15
      pulses = 0; first = -1;
      for (int k = 0; k < 20; k++) begin
         pred_valid = (k < 16);
         pred_pc    = 10'(k);
         cyc();
         if (pred_out_valid === 1'b1) begin
            if (first < 0) first = k;
            pulses++;
         end
      end
      chk("t6_pulses", pulses, 16);
      chk("t6_first", first, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_local_predictor_param.md
Name: bp_local_predictor_param

Overview:
Parametrised local-history branch predictor, successor to the fixed 1024x10 / 1024x3 local predictor. It sits in the tournament predictor's local path beside the global and choice predictors. It has separate predict and update ports and a 2-stage registered lookup with same-cycle update bypass. After reset, a hardware init sweep clears the tables instead of a single-cycle clear.

Parameters:
PC_W, 10, width of branch PC input
LHT_IDX_W, 10, log2 of local history table depth; index = pc[LHT_IDX_W-1:0]
HIST_W, 10, local history length; LPT depth = 2**HIST_W
CTR_W, 3, saturating counter width in the local prediction table
CTR_INIT, 3, LPT value written by the init sweep (weakly not-taken for CTR_W=3)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
pred_valid  in  1  prediction request
pred_pc  in  PC_W  PC of branch to predict
pred_ready  out  1  request accepted when pred_valid && pred_ready; low during init
pred_out_valid  out  1  prediction result valid (single-cycle pulse per request)
pred_taken  out  1  predicted direction = MSB of counter
pred_hist  out  HIST_W  local history used; returned with the later update
pred_ctr  out  CTR_W  raw counter value (for choice logic/debug)
upd_valid  in  1  resolved-branch update
upd_pc  in  PC_W  PC of resolved branch
upd_hist  in  HIST_W  pred_hist returned for this branch
upd_taken  in  1  actual outcome
init_busy  out  1  init sweep in progress

Behaviour:
- Reset (sync): pred_out_valid=0, pred_taken=0, pred_hist=0, pred_ctr=0, init_busy=1, pipeline valids cleared, FSM -> INIT, sweep index=0.
- FSM INIT: each cycle, write LHT[idx]=0 (if idx < 2**LHT_IDX_W) and LPT[idx]=CTR_INIT (if idx < 2**HIST_W). Increment idx. Leave INIT after idx reaches max(2**LHT_IDX_W, 2**HIST_W)-1, i.e. 1024 cycles by default. Then enter RUN, with init_busy=0 and pred_ready=1.
- In INIT: pred_ready=0, pred_valid ignored, upd_valid dropped with no table change.
- Reset asserted mid-INIT or mid-RUN: sweep restarts at idx 0; in-flight predictions are discarded (no pred_out_valid).
- Predict pipeline, 2-cycle latency, 1 request/cycle throughput, no stalls:
  - S1 (accept edge): register h = LHT[pred_pc[LHT_IDX_W-1:0]].
  - S2: register c = LPT[h]. Outputs are valid on the edge 2 cycles after accept.
  - Outputs: pred_hist=h, pred_ctr=c, pred_taken=c[CTR_W-1].
  - Outputs hold their last value when pred_out_valid=0.
- Update (RUN, upd_valid=1), single cycle:
  - LHT[upd_pc idx] <= {LHT[idx][HIST_W-2:0], upd_taken}, shifting in at the LSB.
  - LPT[upd_hist] <= sat(c +1 if taken, -1 if not). Saturate at 2**CTR_W-1 and at 0; no wrap.
- Bypass (write-first):
  - If the S1 read index equals the LHT index written in the same cycle, S1 captures the new history.
  - If the S2 read index equals the LPT index written in the same cycle, S2 captures the new counter.
- Predict and update in the same cycle are always both serviced. Only one update per cycle.
- PC bits above LHT_IDX_W are ignored (aliasing allowed).

Decomposition:
- Package bp_pkg: default widths, CTR_INIT, enum state_e {INIT, RUN}, and typedefs hist_t/ctr_t (parametrised by localparam defaults).
- Function sat_update(ctr, taken) in package.
- One natural sub-module: bp_table_1r1w (parametrised depth/width, registered read, write-first bypass), instantiated for LHT and LPT; init writes are muxed onto its write port.

Test Plan:
1. Assert reset 1 cycle -> init_busy=1 and pred_ready=0 for exactly 1024 cycles. Then pred_pc=0x3FF -> 2 cycles later pred_out_valid=1, pred_hist=0, pred_ctr=3, pred_taken=0.
2. Four updates upd_pc=5 taken -> LHT[5]=0x00F. Predict pc=5 -> pred_hist=0x00F.
3. Five updates upd_hist=0x00F taken -> counter 3->7 and saturates at 7; predict -> pred_ctr=7, pred_taken=1. Eight not-taken -> ctr=0, no wrap.
4. Same cycle: pred_pc=5 accepted while upd_pc=5 taken (LHT[5]=0x00F) -> pred_hist=0x01F (bypass). Repeat for LPT index collision in S2.
5. Reset asserted at sweep idx 500 with pred_valid held high -> no pred_out_valid; init_busy stays 1 for a full 1024 cycles after the new reset.
6. Back-to-back pred_valid for pc=0..15 in RUN -> 16 consecutive pred_out_valid pulses, in order, starting 2 cycles after the first accept.
